id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the 5-stage pipelined MIPS CPU; consumes cmdD/PCPlusFourD from fetch.
//  Holds the 32x32 register file (written from WB), decodes control, sign-extends,
//  resolves beq early and returns PCSrcD/PCBranchD to fetch. Registers all EX inputs in ID/EX.
// PARAMETERS
//  (none; datapath fixed at 32 bits, 32 registers)
// PORTS
//  clk          in   1   single clock, all state updates on posedge
//  reset        in   1   synchronous, active-high; sampled on posedge clk
//  cmdD         in   32  instruction from fetch pipeline register
//  PCPlusFourD  in   32  PC+4 of cmdD
//  FlushE       in   1   from hazard unit: load a bubble into ID/EX this edge
//  ForwardAD    in   1   beq operand A uses ALUOutM instead of RF read
//  ForwardBD    in   1   beq operand B uses ALUOutM instead of RF read
//  ALUOutM      in   32  MEM-stage ALU result for branch forwarding
//  RegWriteW    in   1   WB write enable
//  WriteRegW    in   5   WB destination register
//  ResultW      in   32  WB write data
//  PCSrcD       out  1   branch taken (combinational)
//  PCBranchD    out  32  branch target (combinational)
//  RsD,RtD      out  5   cmdD[25:21], cmdD[20:16] for hazard unit
//  RegWriteE,MemtoRegE,MemWriteE,ALUSrcE,RegDstE  out 1 each  registered controls
//  ALUControlE  out  3   registered ALU op
//  RD1E,RD2E,SignImmE  out 32  registered operands / immediate
//  RsE,RtE,RdE  out  5   registered register fields
// BEHAVIOUR
//  - Decode (comb.): lw 100011, sw 101011, beq 000100, addi 001000, R-type 000000 with
//    funct add 100000/sub 100010/and 100100/or 100101/slt 101010.
//    ALUControl: add 010, sub 110, and 000, or 001, slt 111. lw/sw/addi -> 010, beq -> 110.
//  - Any other opcode or R-type funct (incl. cmdD=0): all controls 0 (nop, no RF/mem write).
//  - SignImm = {{16{cmdD[15]}}, cmdD[15:0]}.
//  - RF read comb.; reg 0 always reads 0 and is never written.
//    Write-through: if RegWriteW && WriteRegW!=0 && WriteRegW==read addr -> read returns ResultW.
//  - RF write on posedge when RegWriteW && WriteRegW!=0.
//  - Branch: A = ForwardAD ? ALUOutM : RD1; B = ForwardBD ? ALUOutM : RD2;
//    PCSrcD = BranchD & (A==B). PCBranchD = PCPlusFourD + (SignImm<<2), mod 2^32 (wraps).
//  - ID/EX register, posedge: reset -> every E output 0; else FlushE -> every E output 0;
//    else load decoded values. reset has priority over FlushE. Latency cmdD -> E outputs = 1.
//  - reset also clears all 32 RF entries to 0 (same edge); a WB write on that edge is dropped.
//  - Comb. outputs (PCSrcD, PCBranchD, RsD, RtD) are never gated by reset/FlushE.
// CONFIGURATION
//  ID_BNE_EN defined: opcode 000101 (bne) decoded as branch, ALUControl 110, no writes;
//    PCSrcD = BranchD & (A!=B) for bne, (A==B) for beq.
//  ID_BNE_EN undefined: 000101 is an unknown opcode -> nop, PCSrcD=0.
// TESTING
//  1 reset=1 one edge, then cmdD=0 -> all E outputs 0, RD1E=RD2E=0, PCSrcD=0.
//  2 WB RegWriteW=1,WriteRegW=8,ResultW=0x0000_0005 while cmdD=add $10,$8,$8 (0x01085020)
//    -> same edge RD1E=RD2E=5, RegWriteE=1, RegDstE=1, ALUControlE=010, RdE=10.
//  3 $8=$9=7, cmdD=beq $8,$9,-1 (0x1109FFFF), PCPlusFourD=0x0000_0040
//    -> PCSrcD=1, PCBranchD=0x0000_003C; with ForwardAD=1,ALUOutM=6 -> PCSrcD=0.
//  4 cmdD=lw $2,0x8000($3) with FlushE=1 -> E outputs all 0; next edge FlushE=0
//    -> MemtoRegE=1, ALUSrcE=1, SignImmE=0xFFFF_8000, RtE=2.
//  5 RegWriteW=1, WriteRegW=0, ResultW=0xDEAD_BEEF; then cmdD reads $0 -> RD1E=0.
//  6 ID_BNE_EN on: $4=1,$5=2, bne $4,$5,+2 (0x14850002), PCPlusFourD=0x10 -> PCSrcD=1,
//    PCBranchD=0x18; macro off -> PCSrcD=0, RegWriteE=MemWriteE=0.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: register file, control decode, early branch resolution and ID/EX register.
// Define ID_BNE_EN to also decode bne (opcode 000101) as a branch.
module id_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cmdD,
   input  logic [31:0] PCPlusFourD,
   input  logic        FlushE,
   input  logic        ForwardAD,
   input  logic        ForwardBD,
   input  logic [31:0] ALUOutM,
   input  logic        RegWriteW,
   input  logic [4:0]  WriteRegW,
   input  logic [31:0] ResultW,
   output logic        PCSrcD,
   output logic [31:0] PCBranchD,
   output logic [4:0]  RsD,
   output logic [4:0]  RtD,
   output logic        RegWriteE,
   output logic        MemtoRegE,
   output logic        MemWriteE,
   output logic        ALUSrcE,
   output logic        RegDstE,
   output logic [2:0]  ALUControlE,
   output logic [31:0] RD1E,
   output logic [31:0] RD2E,
   output logic [31:0] SignImmE,
   output logic [4:0]  RsE,
   output logic [4:0]  RtE,
   output logic [4:0]  RdE
);

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rd_field;
   logic        reg_write;
   logic        mem_to_reg;
   logic        mem_write;
   logic        alu_src;
   logic        reg_dst;
   logic        branch;
   logic        is_bne;
   logic [2:0]  alu_control;
   logic [31:0] sign_imm;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] branch_a;
   logic [31:0] branch_b;
   logic        wb_active;
   logic [31:0] regs [32];

   assign opcode   = cmdD[31:26];
   assign funct    = cmdD[5:0];
   assign RsD      = cmdD[25:21];
   assign RtD      = cmdD[20:16];
   assign rd_field = cmdD[15:11];
   assign sign_imm = {{16{cmdD[15]}}, cmdD[15:0]};

   always_comb begin
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      mem_write   = 1'b0;
      alu_src     = 1'b0;
      reg_dst     = 1'b0;
      branch      = 1'b0;
      is_bne      = 1'b0;
      alu_control = 3'b000;
      case (opcode)
         6'b100011: begin
            reg_write   = 1'b1;
            mem_to_reg  = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b010;
         end
         6'b101011: begin
            mem_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b010;
         end
         6'b000100: begin
            branch      = 1'b1;
            alu_control = 3'b110;
         end
         6'b001000: begin
            reg_write   = 1'b1;
            alu_src     = 1'b1;
            alu_control = 3'b010;
         end
         6'b000000: begin
            // Unrecognised funct leaves every control at zero, i.e. a nop.
            case (funct)
               6'b100000: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b010; end
               6'b100010: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b110; end
               6'b100100: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b000; end
               6'b100101: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b001; end
               6'b101010: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b111; end
               default: ;
            endcase
         end
`ifdef ID_BNE_EN
         6'b000101: begin
            branch      = 1'b1;
            is_bne      = 1'b1;
            alu_control = 3'b110;
         end
`endif
         default: ;
      endcase
   end

   assign wb_active = RegWriteW && (WriteRegW != 5'd0);

   // Register 0 is hardwired to zero; a same-cycle WB write bypasses the array.
   always_comb begin
      rd1 = regs[RsD];
      rd2 = regs[RtD];
      if (wb_active && (WriteRegW == RsD)) rd1 = ResultW;
      if (wb_active && (WriteRegW == RtD)) rd2 = ResultW;
      if (RsD == 5'd0) rd1 = 32'd0;
      if (RtD == 5'd0) rd2 = 32'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      end else if (wb_active) begin
         regs[WriteRegW] <= ResultW;
      end
   end

   assign branch_a  = ForwardAD ? ALUOutM : rd1;
   assign branch_b  = ForwardBD ? ALUOutM : rd2;
   assign PCSrcD    = branch & (is_bne ? (branch_a != branch_b) : (branch_a == branch_b));
   assign PCBranchD = PCPlusFourD + {sign_imm[29:0], 2'b00};

   // Reset and flush both load a bubble, so their relative priority is moot.
   always_ff @(posedge clk) begin
      if (reset || FlushE) begin
         RegWriteE   <= 1'b0;
         MemtoRegE   <= 1'b0;
         MemWriteE   <= 1'b0;
         ALUSrcE     <= 1'b0;
         RegDstE     <= 1'b0;
         ALUControlE <= 3'b000;
         RD1E        <= 32'd0;
         RD2E        <= 32'd0;
         SignImmE    <= 32'd0;
         RsE         <= 5'd0;
         RtE         <= 5'd0;
         RdE         <= 5'd0;
      end else begin
         RegWriteE   <= reg_write;
         MemtoRegE   <= mem_to_reg;
         MemWriteE   <= mem_write;
         ALUSrcE     <= alu_src;
         RegDstE     <= reg_dst;
         ALUControlE <= alu_control;
         RD1E        <= rd1;
         RD2E        <= rd2;
         SignImmE    <= sign_imm;
         RsE         <= RsD;
         RtE         <= RtD;
         RdE         <= rd_field;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against an instruction-level model of decode, RF and branch.
// Directed cases pin the model; build with ID_BNE_EN to exercise bne.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cmdD;
   logic [31:0] PCPlusFourD;
   logic        FlushE;
   logic        ForwardAD;
   logic        ForwardBD;
   logic [31:0] ALUOutM;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic        PCSrcD;
   logic [31:0] PCBranchD;
   logic [4:0]  RsD, RtD;
   logic        RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE;
   logic [2:0]  ALUControlE;
   logic [31:0] RD1E, RD2E, SignImmE;
   logic [4:0]  RsE, RtE, RdE;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       rw, m2r, mw, asrc, rdst, br, bne;
      logic [2:0] alu;
   } ctl_t;

   typedef struct packed {
      logic        rw, m2r, mw, asrc, rdst;
      logic [2:0]  alu;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
   } e_t;

   logic [31:0] mrf [32];
   bit          rf_known = 1'b0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .reset(reset), .cmdD(cmdD), .PCPlusFourD(PCPlusFourD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .RsD(RsD), .RtD(RtD),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
      .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ctl_t model_decode(input logic [31:0] ins);
      ctl_t       c;
      logic [5:0] rfun [5];
      logic [2:0] ralu [5];
      c    = '0;
      rfun = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
      ralu = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7};
      if (ins[31:26] == 6'h23) begin c.rw = 1; c.m2r = 1; c.asrc = 1; c.alu = 3'd2; end
      else if (ins[31:26] == 6'h2b) begin c.mw = 1; c.asrc = 1; c.alu = 3'd2; end
      else if (ins[31:26] == 6'h04) begin c.br = 1; c.alu = 3'd6; end
      else if (ins[31:26] == 6'h08) begin c.rw = 1; c.asrc = 1; c.alu = 3'd2; end
      else if (ins[31:26] == 6'h00) begin
         for (int i = 0; i < 5; i++)
            if (ins[5:0] == rfun[i]) begin c.rw = 1; c.rdst = 1; c.alu = ralu[i]; end
      end
`ifdef ID_BNE_EN
      else if (ins[31:26] == 6'h05) begin c.br = 1; c.bne = 1; c.alu = 3'd6; end
`endif
      return c;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (RegWriteW && WriteRegW == a) return ResultW;
      return mrf[a];
   endfunction

   task automatic applyStimulus(input logic rst, input logic [31:0] cmd, input logic [31:0] pc,
                                input logic flush, input logic fa, input logic fb,
                                input logic [31:0] aluout, input logic rw,
                                input logic [4:0] wr, input logic [31:0] res);
      reset = rst; cmdD = cmd; PCPlusFourD = pc; FlushE = flush;
      ForwardAD = fa; ForwardBD = fb; ALUOutM = aluout;
      RegWriteW = rw; WriteRegW = wr; ResultW = res;
   endtask

   task automatic checkOutput(input e_t e);
      check("RegWriteE", 32'(RegWriteE), 32'(e.rw));
      check("MemtoRegE", 32'(MemtoRegE), 32'(e.m2r));
      check("MemWriteE", 32'(MemWriteE), 32'(e.mw));
      check("ALUSrcE", 32'(ALUSrcE), 32'(e.asrc));
      check("RegDstE", 32'(RegDstE), 32'(e.rdst));
      check("ALUControlE", 32'(ALUControlE), 32'(e.alu));
      check("RD1E", RD1E, e.rd1);
      check("RD2E", RD2E, e.rd2);
      check("SignImmE", SignImmE, e.imm);
      check("RsE", 32'(RsE), 32'(e.rs));
      check("RtE", 32'(RtE), 32'(e.rt));
      check("RdE", 32'(RdE), 32'(e.rd));
   endtask

   // Check comb outputs, predict ID/EX contents, advance the model RF, then check after the edge.
   task automatic cycle();
      ctl_t        c;
      e_t          e;
      logic [31:0] a, b, tgt;
      logic        taken;
      #1;
      c     = model_decode(cmdD);
      a     = ForwardAD ? ALUOutM : model_read(cmdD[25:21]);
      b     = ForwardBD ? ALUOutM : model_read(cmdD[20:16]);
      taken = c.br && (c.bne ? (a != b) : (a == b));
      tgt   = PCPlusFourD + 32'(int'($signed(cmdD[15:0])) * 4);
      check("RsD", 32'(RsD), 32'(cmdD[25:21]));
      check("RtD", 32'(RtD), 32'(cmdD[20:16]));
      check("PCBranchD", PCBranchD, tgt);
      if (rf_known) check("PCSrcD", 32'(PCSrcD), 32'(taken));
      e = '0;
      if (!reset && !FlushE) begin
         e.rw = c.rw; e.m2r = c.m2r; e.mw = c.mw; e.asrc = c.asrc; e.rdst = c.rdst; e.alu = c.alu;
         e.rd1 = model_read(cmdD[25:21]);
         e.rd2 = model_read(cmdD[20:16]);
         e.imm = 32'(int'($signed(cmdD[15:0])));
         e.rs = cmdD[25:21]; e.rt = cmdD[20:16]; e.rd = cmdD[15:11];
      end
      if (reset) begin
         for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
         rf_known = 1'b1;
      end else if (RegWriteW && WriteRegW != 5'd0) begin
         mrf[WriteRegW] = ResultW;
      end
      @(posedge clk);
      #1;
      checkOutput(e);
   endtask

   function automatic logic [31:0] random_instr();
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  fn;
      rs  = 5'($urandom_range(0, 7));
      rt  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 4))
         0: fn = 6'h20;
         1: fn = 6'h22;
         2: fn = 6'h24;
         3: fn = 6'h25;
         default: fn = 6'h2a;
      endcase
      case ($urandom_range(0, 9))
         0: return {6'h23, rs, rt, imm};
         1: return {6'h2b, rs, rt, imm};
         2, 9: return {6'h04, rs, rt, imm};
         3: return {6'h08, rs, rt, imm};
         4: return {6'h00, rs, rt, rd, 5'($urandom), fn};
         5: return {6'h00, rs, rt, rd, 5'($urandom), 6'($urandom)};
         6: return {6'h05, rs, rt, imm};
         7: return $urandom;
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      $display("[TB] start");
      // 1: reset then a zero instruction
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t1 RD1E", RD1E, 32'd0);
      check("t1 RegWriteE", 32'(RegWriteE), 32'd0);
      check("t1 PCSrcD", 32'(PCSrcD), 32'd0);

      // 2: write-through of $8 into add $10,$8,$8
      applyStimulus(0, 32'h01085020, 0, 0, 0, 0, 0, 1, 5'd8, 32'd5);
      cycle();
      check("t2 RD1E", RD1E, 32'd5);
      check("t2 RD2E", RD2E, 32'd5);
      check("t2 RegDstE", 32'(RegDstE), 32'd1);
      check("t2 ALUControlE", 32'(ALUControlE), 32'd2);
      check("t2 RdE", 32'(RdE), 32'd10);

      // 3: beq with and without forwarding
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd8, 32'd7);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 32'd7);
      cycle();
      applyStimulus(0, 32'h1109FFFF, 32'h40, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("t3 PCSrcD", 32'(PCSrcD), 32'd1);
      check("t3 PCBranchD", PCBranchD, 32'h3C);
      applyStimulus(0, 32'h1109FFFF, 32'h40, 0, 1, 0, 32'd6, 0, 0, 0);
      #1;
      check("t3 fwd PCSrcD", 32'(PCSrcD), 32'd0);
      cycle();

      // 4: lw flushed, then loaded
      applyStimulus(0, 32'h8C628000, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t4 flush MemtoRegE", 32'(MemtoRegE), 32'd0);
      check("t4 flush SignImmE", SignImmE, 32'd0);
      applyStimulus(0, 32'h8C628000, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t4 MemtoRegE", 32'(MemtoRegE), 32'd1);
      check("t4 ALUSrcE", 32'(ALUSrcE), 32'd1);
      check("t4 SignImmE", SignImmE, 32'hFFFF8000);
      check("t4 RtE", 32'(RtE), 32'd2);

      // 5: writes to $0 are ignored
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF);
      cycle();
      applyStimulus(0, 32'h00005820, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      check("t5 RD1E", RD1E, 32'd0);

      // 6: bne
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'd1);
      cycle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 32'd2);
      cycle();
      applyStimulus(0, 32'h14850002, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      #1;
`ifdef ID_BNE_EN
      check("t6 PCSrcD", 32'(PCSrcD), 32'd1);
`else
      check("t6 PCSrcD", 32'(PCSrcD), 32'd0);
`endif
      check("t6 PCBranchD", PCBranchD, 32'h18);
      cycle();
      check("t6 RegWriteE", 32'(RegWriteE), 32'd0);
      check("t6 MemWriteE", 32'(MemWriteE), 32'd0);

      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 99) == 0, random_instr(), $urandom,
                       $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 3) == 0, 32'($urandom_range(0, 3)),
                       $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
